ad9833_sweep_ctrl: RTL
======================

AD9833_SWEEP_CTRL -- requirements
Module: ad9833_sweep_ctrl

Interface
REQ-001 Parameter DWELL_W, default 24, width of the dwell counter and the dwell input.
REQ-002 Parameter STEP_W, default 16, width of the step-count input and the step index.
REQ-003 Port clk input 1: single system clock; all logic is on its rising edge.
REQ-004 Port rst_n input 1: asynchronous, active-low reset.
REQ-005 Port start input 1: level-sampled request to begin a sweep; ignored while busy=1.
REQ-006 Port abort input 1: request to stop the sweep after the frame in flight.
REQ-007 Port f_start input 28: first frequency word.
REQ-008 Port f_step input 28: per-step increment, unsigned, modulo 2^28.
REQ-009 Port n_steps input STEP_W: number of increments; total frames = n_steps+1.
REQ-010 Port dwell input DWELL_W: clk cycles to hold each frequency before the next frame.
REQ-011 Port busy output 1: sweep in progress.
REQ-012 Port done output 1: one-cycle pulse on normal completion.
REQ-013 Port aborted output 1: one-cycle pulse on completion by abort.
REQ-014 Port step_idx output STEP_W: index of the frame currently issued or dwelling.
REQ-015 Port dds_go output 1: request to the AD9833 serializer.
REQ-016 Port dds_control output 16: control word for the serializer.
REQ-017 Port dds_freq output 28: frequency word for the serializer.
REQ-018 Port dds_go_ack input 1: serializer good_to_reset_go, high once the serializer has left idle.
REQ-019 Port dds_send_complete input 1: serializer one-cycle end-of-frame pulse.

Function
REQ-020 State machine states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, DWELL, FINISH.
REQ-021 IDLE: when start=1, latch f_start, f_step, n_steps and dwell; set step_idx=0 and cur_freq=f_start; set busy=1; go to ISSUE next cycle.
REQ-022 ISSUE: drive dds_freq=cur_freq and dds_control, assert dds_go, go to WAIT_ACK; dds_freq and dds_control hold stable until the next ISSUE.
REQ-023 dds_control: 16'h2100 (B28 and RESET set) for step_idx=0, and 16'h2000 for every later frame.
REQ-024 WAIT_ACK: hold dds_go=1 until dds_go_ack=1, then drop dds_go the following cycle and go to WAIT_DONE.
REQ-025 WAIT_DONE: on dds_send_complete, if the latched abort is set go to FINISH (aborted path).
REQ-026 WAIT_DONE, otherwise: if step_idx==n_steps go to FINISH (done path); else go to DWELL.
REQ-027 A dds_send_complete pulse in any state other than WAIT_DONE is ignored.
REQ-028 DWELL: count dwell cycles, then cur_freq += f_step (wrapping modulo 2^28), step_idx += 1, and go to ISSUE.
REQ-029 dwell=0 means DWELL lasts exactly one cycle (the update cycle).
REQ-030 No dwell follows the final frame.
REQ-031 FINISH (one cycle): pulse done or aborted (never both), clear busy, return to IDLE.
REQ-032 A start held high in FINISH is not accepted until the first cycle of IDLE.
REQ-033 abort is latched whenever busy=1 and cleared in IDLE.
REQ-034 The frame in flight always completes; dds_go is never withdrawn before dds_go_ack.
REQ-035 abort asserted in the same cycle as the final dds_send_complete gives aborted, not done.
REQ-036 n_steps=0: one frame, then done.
REQ-037 Latched parameters are immune to input changes during busy.

Reset
REQ-038 rst_n=0 asynchronously forces IDLE and sets busy, done, aborted, dds_go, step_idx, dds_control, dds_freq and the internal counters to 0, and clears the abort latch.
REQ-039 Reset mid-frame takes effect immediately; the serializer (no reset) is expected to finish its frame and return to idle on its own, and the block ignores the stray dds_send_complete that results.

Structure
REQ-040 Shared package ad9833_pkg holds the state enumeration, CTRL_INIT=16'h2100, CTRL_RUN=16'h2000 and the frequency width constant 28.
REQ-041 One sub-module, ad9833_dwell_timer (load, count, expire), is instantiated for DWELL; everything else is flat.

Verification
REQ-042 Basic sweep: f_start=1000, f_step=500, n_steps=3, dwell=20, with the serializer model at CLKS_PER_BIT=4 -> 4 frames with freq 1000/1500/2000/2500, control 2100/2000/2000/2000, single done pulse, busy low after.
REQ-043 Wrap-around: f_start=28'hFFFFFF0, f_step=32, n_steps=1 -> second frame freq 28'h0000010.
REQ-044 Abort: abort pulsed during frame 1 of an n_steps=5 sweep -> frame 1 completes, no frame 2, aborted pulse, done never asserted.
REQ-045 Edge cases: n_steps=0 and dwell=0 -> one frame at control 2100 then done; in another run, consecutive frames separated by exactly the minimum gap.
REQ-046 Reset mid-WAIT_DONE: rst_n low for 3 cycles -> all outputs 0 immediately; the late dds_send_complete is ignored; a new start runs a correct sweep.
REQ-047 Handshake check: dds_go stays high until dds_go_ack and is low within 1 cycle after; start during busy has no effect.

Source files
------------

// File: rtl/ad9833_pkg.sv
// Shared definitions for the AD9833 frequency-sweep controller: state encoding,
// control-word constants and the frequency word width.
package ad9833_pkg;

    localparam int FREQ_W = 28;

    localparam logic [15:0] CTRL_INIT = 16'h2100;
    localparam logic [15:0] CTRL_RUN  = 16'h2000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_WAIT_DONE,
        ST_DWELL,
        ST_FINISH
    } sweep_state_t;

    // First frame of a sweep also resets the DDS core so it starts phase-clean
    function automatic logic [15:0] ctrl_word(input logic i_first);
        return i_first ? CTRL_INIT : CTRL_RUN;
    endfunction

endpackage

// File: rtl/ad9833_dwell_timer.sv
// Down-counter used to hold each swept frequency: load a cycle count, count it
// down while enabled, and flag expiry once it reaches zero.
module ad9833_dwell_timer #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_count,
    output logic         o_expire
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_count && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/ad9833_sweep_ctrl.sv
// Frequency-sweep sequencer for an AD9833 serializer: issues n_steps+1 frames
// with a linearly stepped frequency word, dwelling between frames.
module ad9833_sweep_ctrl
    import ad9833_pkg::*;
#(
    parameter int DWELL_W = 24,
    parameter int STEP_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [FREQ_W-1:0]  f_start,
    input  logic [FREQ_W-1:0]  f_step,
    input  logic [STEP_W-1:0]  n_steps,
    input  logic [DWELL_W-1:0] dwell,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic [STEP_W-1:0]  step_idx,
    output logic               dds_go,
    output logic [15:0]        dds_control,
    output logic [FREQ_W-1:0]  dds_freq,
    input  logic               dds_go_ack,
    input  logic               dds_send_complete
);

    sweep_state_t r_state, w_state_next;

    logic               r_busy, w_busy_next;
    logic               r_done, w_done_next;
    logic               r_aborted, w_aborted_next;
    logic               r_dds_go, w_dds_go_next;
    logic [STEP_W-1:0]  r_step_idx, w_step_idx_next;
    logic [15:0]        r_dds_control, w_dds_control_next;
    logic [FREQ_W-1:0]  r_dds_freq, w_dds_freq_next;
    logic [FREQ_W-1:0]  r_cur_freq, w_cur_freq_next;
    logic [FREQ_W-1:0]  r_f_step, w_f_step_next;
    logic [STEP_W-1:0]  r_n_steps, w_n_steps_next;
    logic [DWELL_W-1:0] r_dwell, w_dwell_next;
    logic               r_abort_lat, w_abort_lat_next;

    logic w_tmr_load;
    logic w_tmr_count;
    logic w_tmr_expire;
    logic w_abort_seen;

    // An abort arriving alongside the final end-of-frame still wins over done
    assign w_abort_seen = r_abort_lat | abort;

    always_comb begin
        w_state_next       = r_state;
        w_busy_next        = r_busy;
        w_done_next        = 1'b0;
        w_aborted_next     = 1'b0;
        w_dds_go_next      = r_dds_go;
        w_step_idx_next    = r_step_idx;
        w_dds_control_next = r_dds_control;
        w_dds_freq_next    = r_dds_freq;
        w_cur_freq_next    = r_cur_freq;
        w_f_step_next      = r_f_step;
        w_n_steps_next     = r_n_steps;
        w_dwell_next       = r_dwell;
        w_abort_lat_next   = r_busy ? (r_abort_lat | abort) : r_abort_lat;
        w_tmr_load         = 1'b0;
        w_tmr_count        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_abort_lat_next = 1'b0;
                if (start) begin
                    w_cur_freq_next = f_start;
                    w_f_step_next   = f_step;
                    w_n_steps_next  = n_steps;
                    w_dwell_next    = dwell;
                    w_step_idx_next = '0;
                    w_busy_next     = 1'b1;
                    w_state_next    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_dds_freq_next    = r_cur_freq;
                w_dds_control_next = ctrl_word(r_step_idx == '0);
                w_dds_go_next      = 1'b1;
                w_state_next       = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (dds_go_ack) begin
                    w_dds_go_next = 1'b0;
                    w_state_next  = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (dds_send_complete) begin
                    if (w_abort_seen) begin
                        w_aborted_next = 1'b1;
                        w_busy_next    = 1'b0;
                        w_state_next   = ST_FINISH;
                    end else if (r_step_idx == r_n_steps) begin
                        w_done_next  = 1'b1;
                        w_busy_next  = 1'b0;
                        w_state_next = ST_FINISH;
                    end else begin
                        w_tmr_load   = 1'b1;
                        w_state_next = ST_DWELL;
                    end
                end
            end
            ST_DWELL: begin
                w_tmr_count = 1'b1;
                if (w_tmr_expire) begin
                    w_cur_freq_next = r_cur_freq + r_f_step;
                    w_step_idx_next = r_step_idx + STEP_W'(1);
                    w_state_next    = ST_ISSUE;
                end
            end
            ST_FINISH: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_aborted     <= 1'b0;
            r_dds_go      <= 1'b0;
            r_step_idx    <= '0;
            r_dds_control <= '0;
            r_dds_freq    <= '0;
            r_cur_freq    <= '0;
            r_f_step      <= '0;
            r_n_steps     <= '0;
            r_dwell       <= '0;
            r_abort_lat   <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_busy        <= w_busy_next;
            r_done        <= w_done_next;
            r_aborted     <= w_aborted_next;
            r_dds_go      <= w_dds_go_next;
            r_step_idx    <= w_step_idx_next;
            r_dds_control <= w_dds_control_next;
            r_dds_freq    <= w_dds_freq_next;
            r_cur_freq    <= w_cur_freq_next;
            r_f_step      <= w_f_step_next;
            r_n_steps     <= w_n_steps_next;
            r_dwell       <= w_dwell_next;
            r_abort_lat   <= w_abort_lat_next;
        end
    end

    ad9833_dwell_timer #(
        .W(DWELL_W)
    ) u_dwell_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (r_dwell),
        .i_count    (w_tmr_count),
        .o_expire   (w_tmr_expire)
    );

    assign busy        = r_busy;
    assign done        = r_done;
    assign aborted     = r_aborted;
    assign dds_go      = r_dds_go;
    assign step_idx    = r_step_idx;
    assign dds_control = r_dds_control;
    assign dds_freq    = r_dds_freq;

endmodule
